control_unit: RTL and testbench

Instruction sequencer for the 8-bit CPU. It fetches 16-bit instructions from program memory, decodes them, and drives the ALU strobes (`c_ain`, `c_bin`, `c_alu`, `c_aout`) and the 3-bit ALU opcode. It also drives the ALU's data inputs from immediates or data memory and resolves jumps using the ALU `flag`. It sits directly upstream of `alu`, which is its only consumer of control.

---
 rtl/control_unit_if.sv | 53 +++++
 rtl/control_unit.sv | 144 ++++++++++++++
 tb/tb_control_unit.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_unit_if.sv
// Bus bundle between the instruction sequencer and its surroundings:
// program memory, data memory and the ALU control and data inputs.
interface control_unit_if #(
    parameter int PC_W = 8
);
    logic [PC_W-1:0] imem_addr;
    logic [15:0]     imem_data;
    logic [7:0]      dmem_addr;
    logic            dmem_we;
    logic [7:0]      dmem_rdata;
    logic [2:0]      alu_op;
    logic [7:0]      a_data;
    logic [7:0]      b_data;
    logic            c_ain;
    logic            c_bin;
    logic            c_alu;
    logic            c_aout;
    logic            flag;

    // Sequencer side
    modport master (
        output imem_addr,
        input  imem_data,
        output dmem_addr,
        output dmem_we,
        input  dmem_rdata,
        output alu_op,
        output a_data,
        output b_data,
        output c_ain,
        output c_bin,
        output c_alu,
        output c_aout,
        input  flag
    );

    // Memory / ALU side
    modport slave (
        input  imem_addr,
        output imem_data,
        input  dmem_addr,
        input  dmem_we,
        output dmem_rdata,
        input  alu_op,
        input  a_data,
        input  b_data,
        input  c_ain,
        input  c_bin,
        input  c_alu,
        input  c_aout,
        output flag
    );
endinterface

// File: rtl/control_unit.sv
// Instruction sequencer for the 8-bit CPU: fetches 16-bit instructions,
// decodes them, and drives ALU strobes, ALU operands and data memory.
// Strobes are combinational decodes of state + ir, so each one is a
// single-cycle pulse tied to EXEC1 or EXEC2.
module control_unit #(
    parameter int PC_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    control_unit_if.master   bus,
    output logic             halted,
    output logic [PC_W-1:0]  pc
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC1  = 3'd2,
        EXEC2  = 3'd3,
        HALTED = 3'd4
    } state_t;

    localparam logic [3:0] OP_LDA  = 4'd8;
    localparam logic [3:0] OP_LDB  = 4'd9;
    localparam logic [3:0] OP_STA  = 4'd10;
    localparam logic [3:0] OP_JMP  = 4'd11;
    localparam logic [3:0] OP_JF   = 4'd12;
    localparam logic [3:0] OP_HALT = 4'd15;

    state_t          state_reg;
    logic [PC_W-1:0] pc_reg;
    logic [15:0]     ir_reg;

    logic [3:0]      op;
    logic [7:0]      imm;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_target;
    logic            op_is_alu_rr;
    logic            op_is_alu_imm;
    logic            op_is_load;
    logic            unused_ir_bits;

    assign op             = ir_reg[15:12];
    assign imm            = ir_reg[7:0];
    assign pc_inc         = pc_reg + PC_W'(1);
    assign pc_target      = PC_W'(imm);
    assign op_is_alu_rr   = (op == 4'd0) || (op == 4'd1);
    assign op_is_alu_imm  = (op >= 4'd2) && (op <= 4'd6);
    assign op_is_load     = (op == OP_LDA) || (op == OP_LDB);
    assign unused_ir_bits = ^ir_reg[11:8];

    assign bus.imem_addr = pc_reg;
    assign pc            = pc_reg;
    assign halted        = (state_reg == HALTED);

    // Sequencer FSM: state, program counter and instruction register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= FETCH;
            pc_reg    <= '0;
            ir_reg    <= '0;
        end else begin
            case (state_reg)
                FETCH: begin
                    if (run) begin
                        state_reg <= DECODE;
                    end
                end
                DECODE: begin
                    ir_reg    <= bus.imem_data;
                    state_reg <= EXEC1;
                end
                EXEC1: begin
                    if (op_is_alu_imm || op_is_load) begin
                        state_reg <= EXEC2;
                    end else if (op == OP_HALT) begin
                        state_reg <= HALTED;
                    end else if (op == OP_JMP) begin
                        pc_reg    <= pc_target;
                        state_reg <= FETCH;
                    end else if (op == OP_JF) begin
                        pc_reg    <= bus.flag ? pc_target : pc_inc;
                        state_reg <= FETCH;
                    end else begin
                        // ADD/SUB, STA and the NOP opcodes all finish here
                        pc_reg    <= pc_inc;
                        state_reg <= FETCH;
                    end
                end
                EXEC2: begin
                    pc_reg    <= pc_inc;
                    state_reg <= FETCH;
                end
                HALTED: begin
                    state_reg <= HALTED;
                end
                default: begin
                    state_reg <= FETCH;
                end
            endcase
        end
    end

    // Strobe and operand decode; forced idle while reset is asserted
    always_comb begin
        bus.dmem_addr = '0;
        bus.dmem_we   = 1'b0;
        bus.alu_op    = '0;
        bus.a_data    = '0;
        bus.b_data    = '0;
        bus.c_ain     = 1'b0;
        bus.c_bin     = 1'b0;
        bus.c_alu     = 1'b0;
        bus.c_aout    = 1'b0;
        if (!reset) begin
            if (state_reg == EXEC1) begin
                if (op_is_alu_rr) begin
                    bus.c_alu  = 1'b1;
                    bus.alu_op = ir_reg[14:12];
                end else if (op_is_alu_imm) begin
                    bus.b_data = imm;
                    bus.c_bin  = 1'b1;
                end else if (op_is_load) begin
                    bus.dmem_addr = imm;
                end else if (op == OP_STA) begin
                    bus.dmem_addr = imm;
                    bus.c_aout    = 1'b1;
                    bus.dmem_we   = 1'b1;
                end
            end else if (state_reg == EXEC2) begin
                if (op_is_alu_imm) begin
                    bus.c_alu  = 1'b1;
                    bus.alu_op = ir_reg[14:12];
                end else if (op == OP_LDA) begin
                    bus.a_data = bus.dmem_rdata;
                    bus.c_ain  = 1'b1;
                end else if (op == OP_LDB) begin
                    bus.b_data = bus.dmem_rdata;
                    bus.c_bin  = 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_control_unit.sv
// Directed testbench for control_unit with behavioural program memory,
// data memory and a minimal ALU (A/B registers, ADD/SUB/ADDI, F compare).
module tb_control_unit;
    logic       clk;
    logic       reset;
    logic       run;
    logic       halted;
    logic [7:0] pc;

    int checks;
    int failures;

    control_unit_if #(.PC_W(8)) bus ();

    control_unit #(.PC_W(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .run    (run),
        .bus    (bus.master),
        .halted (halted),
        .pc     (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] imem [0:255];
    logic [7:0]  dmem [0:255];
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        pre_we;
    logic [7:0]  pre_addr;
    logic [7:0]  pre_data;

    // Program memory with registered read
    always @(posedge clk) begin
        bus.imem_data <= imem[bus.imem_addr];
    end

    // Data memory: registered read, write captures the ALU A register
    always @(posedge clk) begin
        if (pre_we) dmem[pre_addr] <= pre_data;
        else if (bus.dmem_we) dmem[bus.dmem_addr] <= alu_a;
        bus.dmem_rdata <= dmem[bus.dmem_addr];
    end

    // Minimal ALU
    always @(posedge clk) begin
        if (reset) begin
            alu_a    <= 8'd0;
            alu_b    <= 8'd0;
            bus.flag <= 1'b0;
        end else begin
            if (bus.c_ain) alu_a <= bus.a_data;
            if (bus.c_bin) alu_b <= bus.b_data;
            if (bus.c_alu) begin
                case (bus.alu_op)
                    3'd0: alu_a <= alu_a + alu_b;
                    3'd1: alu_a <= alu_a - alu_b;
                    3'd2: alu_a <= alu_a + alu_b;
                    3'd6: bus.flag <= (alu_a == alu_b);
                    default: ;
                endcase
            end
        end
    end

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = 16'h7000;
    endtask

    task automatic preload(input logic [7:0] addr, input logic [7:0] data);
        pre_we   = 1'b1;
        pre_addr = addr;
        pre_data = data;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    // Leaves the bench at the negedge where the DUT sits in FETCH, pc 0
    task automatic apply_reset(input logic run_val);
        reset = 1'b1;
        run   = run_val;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        run   = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (pc !== 8'd0 || halted !== 1'b0 || bus.imem_addr !== 8'd0) begin
            failures++;
            $display("FAIL reset_pc: pc=%0h halted=%0b imem_addr=%0h expected 0 0 0", pc, halted, bus.imem_addr);
        end
        checks++;
        if ({bus.c_ain, bus.c_bin, bus.c_alu, bus.c_aout, bus.dmem_we} !== 5'b0 ||
            bus.a_data !== 8'd0 || bus.b_data !== 8'd0 || bus.alu_op !== 3'd0 || bus.dmem_addr !== 8'd0) begin
            failures++;
            $display("FAIL reset_outputs: strobes=%05b a=%0h b=%0h op=%0d daddr=%0h expected all 0",
                     {bus.c_ain, bus.c_bin, bus.c_alu, bus.c_aout, bus.dmem_we},
                     bus.a_data, bus.b_data, bus.alu_op, bus.dmem_addr);
        end
        $display("reset: pc=%0h halted=%0b", pc, halted);
    endtask

    task automatic test_back_to_back_addi();
        reset = 1'b1;
        clear_imem();
        imem[0] = 16'h2005;
        imem[1] = 16'h2003;
        imem[2] = 16'hF000;
        apply_reset(1'b1);
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.c_bin, bus.c_alu} !== 2'b10 || bus.b_data !== 8'd5) begin
            failures++;
            $display("FAIL addi1_bin: c_bin=%0b c_alu=%0b b_data=%0h expected 1 0 05", bus.c_bin, bus.c_alu, bus.b_data);
        end
        @(negedge clk);
        checks++;
        if ({bus.c_bin, bus.c_alu} !== 2'b01 || bus.alu_op !== 3'd2 || bus.b_data !== 8'd0) begin
            failures++;
            $display("FAIL addi1_alu: c_bin=%0b c_alu=%0b alu_op=%0d b_data=%0h expected 0 1 2 00",
                     bus.c_bin, bus.c_alu, bus.alu_op, bus.b_data);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.c_bin !== 1'b1 || bus.b_data !== 8'd3 || pc !== 8'd1) begin
            failures++;
            $display("FAIL addi2_bin: c_bin=%0b b_data=%0h pc=%0h expected 1 03 01", bus.c_bin, bus.b_data, pc);
        end
        @(negedge clk);
        checks++;
        if (bus.c_alu !== 1'b1 || bus.alu_op !== 3'd2) begin
            failures++;
            $display("FAIL addi2_alu: c_alu=%0b alu_op=%0d expected 1 2", bus.c_alu, bus.alu_op);
        end
        @(negedge clk);
        checks++;
        if (pc !== 8'd2 || alu_a !== 8'd8) begin
            failures++;
            $display("FAIL addi_result: pc=%0h alu_a=%0h expected 02 08", pc, alu_a);
        end
        $display("addi x2: pc=%0h alu_a=%0h", pc, alu_a);
    endtask

    task automatic test_load_store();
        reset = 1'b1;
        clear_imem();
        imem[0] = 16'h8010;
        imem[1] = 16'hA011;
        imem[2] = 16'hF000;
        preload(8'h10, 8'h2A);
        preload(8'h11, 8'h00);
        apply_reset(1'b1);
        repeat (2) @(negedge clk);
        checks++;
        if (bus.dmem_addr !== 8'h10 || bus.c_ain !== 1'b0) begin
            failures++;
            $display("FAIL lda_addr: dmem_addr=%0h c_ain=%0b expected 10 0", bus.dmem_addr, bus.c_ain);
        end
        @(negedge clk);
        checks++;
        if (bus.c_ain !== 1'b1 || bus.a_data !== 8'h2A) begin
            failures++;
            $display("FAIL lda_ain: c_ain=%0b a_data=%0h expected 1 2a", bus.c_ain, bus.a_data);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.dmem_we !== 1'b1 || bus.c_aout !== 1'b1 || bus.dmem_addr !== 8'h11) begin
            failures++;
            $display("FAIL sta_strobe: dmem_we=%0b c_aout=%0b dmem_addr=%0h expected 1 1 11",
                     bus.dmem_we, bus.c_aout, bus.dmem_addr);
        end
        @(negedge clk);
        checks++;
        if (dmem[8'h11] !== 8'h2A || pc !== 8'd2 || bus.dmem_we !== 1'b0) begin
            failures++;
            $display("FAIL sta_mem: mem11=%0h pc=%0h dmem_we=%0b expected 2a 02 0", dmem[8'h11], pc, bus.dmem_we);
        end
        $display("lda/sta: mem[11]=%0h pc=%0h", dmem[8'h11], pc);
    endtask

    task automatic test_flag_branch(input logic [7:0] a_val, input logic [7:0] exp_pc);
        reset = 1'b1;
        clear_imem();
        imem[0] = 16'h8020;
        imem[1] = 16'h6007;
        imem[2] = 16'hC040;
        preload(8'h20, a_val);
        apply_reset(1'b1);
        repeat (6) @(negedge clk);
        checks++;
        if (bus.c_bin !== 1'b1 || bus.b_data !== 8'd7) begin
            failures++;
            $display("FAIL f_bin: c_bin=%0b b_data=%0h expected 1 07", bus.c_bin, bus.b_data);
        end
        @(negedge clk);
        checks++;
        if (bus.c_alu !== 1'b1 || bus.alu_op !== 3'd6) begin
            failures++;
            $display("FAIL f_alu: c_alu=%0b alu_op=%0d expected 1 6", bus.c_alu, bus.alu_op);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (pc !== exp_pc) begin
            failures++;
            $display("FAIL jf_pc: a=%0h pc=%0h expected %0h", a_val, pc, exp_pc);
        end
        $display("F/JF: a=%0h pc=%0h", a_val, pc);
    endtask

    task automatic test_wrap_jmp();
        reset = 1'b1;
        clear_imem();
        imem[0]   = 16'hB0FF;
        imem[255] = 16'h7000;
        apply_reset(1'b1);
        repeat (3) @(negedge clk);
        checks++;
        if (pc !== 8'hFF) begin
            failures++;
            $display("FAIL jmp_ff: pc=%0h expected ff", pc);
        end
        imem[0] = 16'hB005;
        repeat (3) @(negedge clk);
        checks++;
        if (pc !== 8'h00) begin
            failures++;
            $display("FAIL nop_wrap: pc=%0h expected 00", pc);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (pc !== 8'h05) begin
            failures++;
            $display("FAIL jmp_05: pc=%0h expected 05", pc);
        end
        $display("wrap/jmp: pc=%0h", pc);
    endtask

    task automatic test_run_hold();
        reset = 1'b1;
        clear_imem();
        imem[0] = 16'h7000;
        imem[1] = 16'h2001;
        imem[2] = 16'hF000;
        apply_reset(1'b1);
        @(negedge clk);
        run = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (pc !== 8'd1 || {bus.c_ain, bus.c_bin, bus.c_alu, bus.c_aout, bus.dmem_we} !== 5'b0) begin
                failures++;
                $display("FAIL run_hold: cycle=%0d pc=%0h strobes=%05b expected 01 00000",
                         i, pc, {bus.c_ain, bus.c_bin, bus.c_alu, bus.c_aout, bus.dmem_we});
            end
            @(negedge clk);
        end
        run = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.c_bin !== 1'b1 || bus.b_data !== 8'd1 || pc !== 8'd1) begin
            failures++;
            $display("FAIL run_resume: c_bin=%0b b_data=%0h pc=%0h expected 1 01 01", bus.c_bin, bus.b_data, pc);
        end
        $display("run hold/resume: pc=%0h", pc);
    endtask

    task automatic test_halt();
        reset = 1'b1;
        clear_imem();
        imem[0] = 16'hF000;
        apply_reset(1'b1);
        repeat (2) @(negedge clk);
        checks++;
        if (halted !== 1'b0) begin
            failures++;
            $display("FAIL halt_exec1: halted=%0b expected 0", halted);
        end
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (halted !== 1'b1 || pc !== 8'd0 ||
                {bus.c_ain, bus.c_bin, bus.c_alu, bus.c_aout, bus.dmem_we} !== 5'b0) begin
                failures++;
                $display("FAIL halted_idle: cycle=%0d halted=%0b pc=%0h strobes=%05b expected 1 00 00000",
                         i, halted, pc, {bus.c_ain, bus.c_bin, bus.c_alu, bus.c_aout, bus.dmem_we});
            end
            @(negedge clk);
        end
        $display("halt: halted=%0b pc=%0h", halted, pc);
    endtask

    task automatic test_reset_exec2();
        reset = 1'b1;
        clear_imem();
        imem[0] = 16'h7000;
        imem[1] = 16'h8010;
        preload(8'h10, 8'h55);
        apply_reset(1'b1);
        checks++;
        if (halted !== 1'b0 || pc !== 8'd0) begin
            failures++;
            $display("FAIL reset_from_halt: halted=%0b pc=%0h expected 0 00", halted, pc);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (pc !== 8'd1) begin
            failures++;
            $display("FAIL pre_lda_pc: pc=%0h expected 01", pc);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (bus.c_ain !== 1'b0 || bus.a_data !== 8'd0) begin
            failures++;
            $display("FAIL reset_exec2_strobe: c_ain=%0b a_data=%0h expected 0 00", bus.c_ain, bus.a_data);
        end
        @(negedge clk);
        checks++;
        if (pc !== 8'd0 || bus.c_ain !== 1'b0) begin
            failures++;
            $display("FAIL reset_exec2_pc: pc=%0h c_ain=%0b expected 00 0", pc, bus.c_ain);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (pc !== 8'd1) begin
            failures++;
            $display("FAIL restart_pc: pc=%0h expected 01", pc);
        end
        $display("reset in exec2: pc=%0h", pc);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        run      = 1'b0;
        pre_we   = 1'b0;
        pre_addr = 8'd0;
        pre_data = 8'd0;
        clear_imem();
        test_reset();
        test_back_to_back_addi();
        test_load_store();
        test_flag_branch(8'd7, 8'h40);
        test_flag_branch(8'd6, 8'h03);
        test_wrap_jmp();
        test_run_hold();
        test_halt();
        test_reset_exec2();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
